// File: rtl/apb_servo_pwm.sv
// APB3 two-channel servo PWM generator (pan/tilt) with double-buffered period and duty.
// Shadow registers are written by firmware; active copies reload only at a period wrap or while disabled.
module apb_servo_pwm #(
  parameter int CNT_W      = 21,
  parameter int PERIOD_RST = 2000000,
  parameter int DUTY_RST   = 150000
) (
  input  logic        PCLK,
  input  logic        PRESERN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [7:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        PWM_PAN,
  output logic        PWM_TILT
);

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_PERIOD = 3'd1;
  localparam logic [2:0] REG_DUTY0  = 3'd2;
  localparam logic [2:0] REG_DUTY1  = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;
  localparam logic [2:0] REG_COUNT  = 3'd5;

  localparam logic [CNT_W-1:0] PERIOD_INIT = CNT_W'(PERIOD_RST);
  localparam logic [CNT_W-1:0] DUTY_INIT   = CNT_W'(DUTY_RST);
  localparam logic [CNT_W-1:0] MIN_PERIOD  = CNT_W'(2);

  logic [2:0]       reg_sel;
  logic             access;
  logic             wr_commit;
  logic             shadow_wr;
  logic             load_active;
  logic             wrap;
  logic [CNT_W-1:0] wdata;

  logic             en;
  logic             pending;
  logic [CNT_W-1:0] period_sh;
  logic [CNT_W-1:0] duty0_sh;
  logic [CNT_W-1:0] duty1_sh;
  logic [CNT_W-1:0] period_act;
  logic [CNT_W-1:0] duty0_act;
  logic [CNT_W-1:0] duty1_act;
  logic [CNT_W-1:0] cnt;
  logic             unused_bits;

  // Only addresses 0..3 are writable; anything else errors and must not touch state.
  assign reg_sel     = PADDR[4:2];
  assign access      = PSEL & PENABLE;
  assign wr_commit   = access & PWRITE & ~reg_sel[2];
  assign shadow_wr   = wr_commit & (reg_sel != REG_CTRL);
  assign wdata       = PWDATA[CNT_W-1:0];
  assign wrap        = (cnt == period_act - 1'b1);
  assign load_active = ~en | wrap;
  assign unused_bits = &{1'b0, PADDR[7:5], PADDR[1:0], PWDATA[31:CNT_W]};

  assign PREADY  = 1'b1;
  assign PSLVERR = access & (PWRITE ? reg_sel[2] : (reg_sel[2] & reg_sel[1]));

  always_comb begin
    PRDATA = '0;
    if (PSEL & ~PWRITE) begin
      case (reg_sel)
        REG_CTRL:   PRDATA = {31'b0, en};
        REG_PERIOD: PRDATA = 32'(period_sh);
        REG_DUTY0:  PRDATA = 32'(duty0_sh);
        REG_DUTY1:  PRDATA = 32'(duty1_sh);
        REG_STATUS: PRDATA = {30'b0, pending, en};
        REG_COUNT:  PRDATA = 32'(cnt);
        default:    PRDATA = '0;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      en        <= 1'b0;
      period_sh <= PERIOD_INIT;
      duty0_sh  <= DUTY_INIT;
      duty1_sh  <= DUTY_INIT;
    end else if (wr_commit) begin
      case (reg_sel)
        REG_CTRL:   en <= PWDATA[0];
        REG_PERIOD: period_sh <= (wdata < MIN_PERIOD) ? MIN_PERIOD : wdata;
        REG_DUTY0:  duty0_sh <= wdata;
        REG_DUTY1:  duty1_sh <= wdata;
        default:    ;
      endcase
    end
  end

  // A write landing on the reload edge keeps pending set, so it takes effect one period later.
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      cnt        <= '0;
      period_act <= PERIOD_INIT;
      duty0_act  <= DUTY_INIT;
      duty1_act  <= DUTY_INIT;
      pending    <= 1'b0;
    end else begin
      if (load_active) begin
        cnt        <= '0;
        period_act <= period_sh;
        duty0_act  <= duty0_sh;
        duty1_act  <= duty1_sh;
      end else begin
        cnt <= cnt + 1'b1;
      end
      pending <= shadow_wr | (pending & ~load_active);
    end
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      PWM_PAN  <= 1'b0;
      PWM_TILT <= 1'b0;
    end else begin
      PWM_PAN  <= en & (cnt < duty0_act);
      PWM_TILT <= en & (cnt < duty1_act);
    end
  end

endmodule

// File: tb/tb_apb_servo_pwm.sv
// Self-checking bench for apb_servo_pwm: directed scenarios plus randomized period/duty programming
// compared against a cycle-level reference model of the register and PWM rules.
module tb_apb_servo_pwm;

  logic        PCLK = 1'b0;
  logic        PRESERN = 1'b1;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [7:0]  PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        PWM_PAN;
  logic        PWM_TILT;

  int checks = 0;
  int failures = 0;

  apb_servo_pwm dut (
    .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .PWM_PAN(PWM_PAN), .PWM_TILT(PWM_TILT)
  );

  always #5 PCLK = ~PCLK;

  // Reference model: integer shadow/active values, counter and registered PWM.
  int   m_per_sh, m_per, m_d0_sh, m_d0, m_d1_sh, m_d1, m_cnt;
  logic m_en, m_pend, m_pan, m_tilt;
  logic [2:0] m_a;
  int   m_wd;
  logic m_wr;
  assign m_a  = PADDR[4:2];
  assign m_wd = int'(PWDATA[20:0]);
  assign m_wr = PSEL & PENABLE & PWRITE & (m_a < 3'd4);

  always @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      m_en <= 1'b0; m_pend <= 1'b0; m_cnt <= 0; m_pan <= 1'b0; m_tilt <= 1'b0;
      m_per_sh <= 2000000; m_per <= 2000000;
      m_d0_sh <= 150000; m_d0 <= 150000; m_d1_sh <= 150000; m_d1 <= 150000;
    end else begin
      m_pan  <= m_en && (m_cnt < m_d0);
      m_tilt <= m_en && (m_cnt < m_d1);
      if (!m_en || m_cnt == m_per - 1) begin
        m_cnt <= 0; m_per <= m_per_sh; m_d0 <= m_d0_sh; m_d1 <= m_d1_sh; m_pend <= 1'b0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
      if (m_wr) begin
        case (m_a)
          3'd0: m_en <= PWDATA[0];
          3'd1: begin m_per_sh <= (m_wd < 2) ? 2 : m_wd; m_pend <= 1'b1; end
          3'd2: begin m_d0_sh <= m_wd; m_pend <= 1'b1; end
          default: begin m_d1_sh <= m_wd; m_pend <= 1'b1; end
        endcase
      end
    end
  end

  function automatic logic [31:0] exp_read(input logic [7:0] a);
    case (a[4:2])
      3'd0: return {31'b0, m_en};
      3'd1: return 32'(m_per_sh);
      3'd2: return 32'(m_d0_sh);
      3'd3: return 32'(m_d1_sh);
      3'd4: return {30'b0, m_pend, m_en};
      3'd5: return 32'(m_cnt);
      default: return 32'h0;
    endcase
  endfunction

  task automatic apb_write(input logic [7:0] addr, input logic [31:0] data, output logic err);
    @(negedge PCLK); PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = addr; PWDATA = data;
    @(negedge PCLK); PENABLE = 1'b1;
    #1 err = PSLVERR;
    @(negedge PCLK); PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] addr, output logic [31:0] data,
                          output logic [31:0] exp, output logic err);
    @(negedge PCLK); PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = addr;
    @(negedge PCLK); PENABLE = 1'b1;
    #1 data = PRDATA; err = PSLVERR; exp = exp_read(addr);
    @(negedge PCLK); PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] got, exp;
    logic err;
    logic [7:0]  addrs [5] = '{8'h04, 8'h08, 8'h0C, 8'h10, 8'h00};
    logic [31:0] vals  [5] = '{32'd2000000, 32'd150000, 32'd150000, 32'h0, 32'h0};
    #1 PRESERN = 1'b0;
    repeat (3) @(negedge PCLK);
    checks++; if (PWM_PAN !== 1'b0 || PWM_TILT !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_pwm got=%b%b exp=00", PWM_PAN, PWM_TILT); end
    checks++; if (PREADY !== 1'b1 || PSLVERR !== 1'b0 || PRDATA !== 32'h0) begin
      failures++; $display("[TB] FAIL reset_bus got=%b/%b/%0h exp=1/0/0", PREADY, PSLVERR, PRDATA); end
    PRESERN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      apb_read(addrs[i], got, exp, err);
      checks++; if (got !== vals[i] || err !== 1'b0 || PREADY !== 1'b1) begin
        failures++;
        $display("[TB] FAIL reset_read addr=%0h got=%0d err=%b exp=%0d", addrs[i], got, err, vals[i]);
      end
    end
  endtask

  task automatic test_pwm_basic();
    logic [31:0] got, exp;
    logic err;
    int highs = 0;
    apb_write(8'h04, 32'd100, err);
    apb_write(8'h08, 32'd25, err);
    apb_write(8'h0C, 32'd0, err);
    apb_write(8'h00, 32'd1, err);
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL basic_wr_err got=%b exp=0", err); end
    for (int i = 0; i < 300; i++) begin
      @(negedge PCLK);
      if (i >= 100 && i < 200) highs += int'(PWM_PAN);
      checks++; if (PWM_PAN !== m_pan || PWM_TILT !== 1'b0) begin
        failures++; $display("[TB] FAIL basic_pwm cyc=%0d got=%b%b exp=%b0", i, PWM_PAN, PWM_TILT, m_pan); end
    end
    checks++; if (highs != 25) begin failures++; $display("[TB] FAIL basic_highs got=%0d exp=25", highs); end
    repeat (3) begin
      apb_read(8'h14, got, exp, err);
      checks++; if (got !== exp || got >= 32'd100) begin
        failures++; $display("[TB] FAIL basic_count got=%0d exp=%0d", got, exp); end
    end
  endtask

  task automatic test_double_buffer();
    logic [31:0] got, exp;
    logic err;
    bit found = 0;
    int highs = 0;
    for (int i = 0; i < 300 && !found; i++) begin @(negedge PCLK); if (m_cnt == 10) found = 1; end
    checks++; if (!found) begin failures++; $display("[TB] FAIL dbuf_wait10 got=timeout exp=cnt10"); end
    apb_write(8'h08, 32'd60, err);
    apb_read(8'h10, got, exp, err);
    checks++; if (got !== 32'h3) begin failures++; $display("[TB] FAIL dbuf_status_pend got=%0h exp=3", got); end
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge PCLK);
      if (m_cnt == 1) found = 1;
      checks++; if (PWM_PAN !== m_pan) begin
        failures++; $display("[TB] FAIL dbuf_old_pulse got=%b exp=%b", PWM_PAN, m_pan); end
    end
    for (int i = 0; i < 100; i++) begin
      highs += int'(PWM_PAN);
      @(negedge PCLK);
    end
    checks++; if (highs != 60) begin failures++; $display("[TB] FAIL dbuf_new_highs got=%0d exp=60", highs); end
    apb_read(8'h10, got, exp, err);
    checks++; if (got !== 32'h1) begin failures++; $display("[TB] FAIL dbuf_status_done got=%0h exp=1", got); end
  endtask

  task automatic test_tilt_and_clamp();
    logic [31:0] got, exp;
    logic err;
    bit found = 0;
    for (int i = 0; i < 300 && !found; i++) begin @(negedge PCLK); if (m_cnt == 50) found = 1; end
    apb_write(8'h0C, 32'd200, err);
    for (int i = 0; i < 300 && found; i++) begin @(negedge PCLK); if (m_cnt == 1) found = 0; end
    checks++; if (found) begin failures++; $display("[TB] FAIL tilt_wait got=timeout exp=wrap"); end
    for (int i = 0; i < 100; i++) begin
      @(negedge PCLK);
      checks++; if (PWM_TILT !== 1'b1) begin
        failures++; $display("[TB] FAIL tilt_high cyc=%0d got=%b exp=1", i, PWM_TILT); end
    end
    apb_write(8'h04, 32'd1, err);
    apb_read(8'h04, got, exp, err);
    checks++; if (got !== 32'd2) begin failures++; $display("[TB] FAIL period_clamp got=%0d exp=2", got); end
    apb_write(8'h04, 32'd100, err);
  endtask

  task automatic test_errors();
    logic [31:0] got, exp;
    logic err;
    logic [7:0]  waddr [3] = '{8'h14, 8'h18, 8'h10};
    logic [7:0]  raddr [2] = '{8'h1C, 8'h18};
    logic [7:0]  caddr [4] = '{8'h00, 8'h04, 8'h08, 8'h0C};
    logic [31:0] cval  [4] = '{32'd1, 32'd100, 32'd60, 32'd200};
    for (int i = 0; i < 3; i++) begin
      apb_write(waddr[i], $urandom, err);
      checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL err_wr addr=%0h got=%b exp=1", waddr[i], err); end
    end
    for (int i = 0; i < 2; i++) begin
      apb_read(raddr[i], got, exp, err);
      checks++; if (err !== 1'b1 || got !== 32'h0) begin
        failures++; $display("[TB] FAIL err_rd addr=%0h got=%b/%0h exp=1/0", raddr[i], err, got); end
    end
    for (int i = 0; i < 4; i++) begin
      apb_read(caddr[i], got, exp, err);
      checks++; if (got !== cval[i] || err !== 1'b0) begin
        failures++; $display("[TB] FAIL err_nochange addr=%0h got=%0d exp=%0d", caddr[i], got, cval[i]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] got, exp;
    logic err;
    logic [7:0] a;
    int per, d0, d1;
    for (int it = 0; it < 6; it++) begin
      per = $urandom_range(3, 40);
      d0  = $urandom_range(0, per + 5);
      d1  = $urandom_range(0, per + 5);
      apb_write(8'h04, ($urandom << 21) | 32'(per), err);
      apb_write(8'h08, ($urandom << 21) | 32'(d0), err);
      apb_write(8'h0C, ($urandom << 21) | 32'(d1), err);
      apb_write(8'h00, ($urandom_range(0, 4) != 0) ? 32'd1 : 32'd0, err);
      for (int i = 0; i < 250; i++) begin
        @(negedge PCLK);
        checks++; if (PWM_PAN !== m_pan || PWM_TILT !== m_tilt) begin
          failures++;
          $display("[TB] FAIL rand_pwm it=%0d cyc=%0d got=%b%b exp=%b%b", it, i, PWM_PAN, PWM_TILT, m_pan, m_tilt);
        end
      end
      repeat (3) begin
        a = {$urandom_range(0, 7) == 0 ? 3'b111 : 3'(int'($urandom)), 3'(int'($urandom_range(0, 7))), 2'b00};
        apb_read(a, got, exp, err);
        checks++; if (got !== exp || err !== (a[4:2] >= 3'd6)) begin
          failures++; $display("[TB] FAIL rand_read addr=%0h got=%0h/%b exp=%0h", a, got, err, exp); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got, exp;
    logic err;
    bit found = 0;
    logic [7:0]  addrs [5] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10};
    logic [31:0] vals  [5] = '{32'h0, 32'd2000000, 32'd150000, 32'd150000, 32'h0};
    apb_write(8'h00, 32'd0, err);
    apb_write(8'h04, 32'd100, err);
    apb_write(8'h08, 32'd25, err);
    apb_write(8'h00, 32'd1, err);
    for (int i = 0; i < 300 && !found; i++) begin @(negedge PCLK); if (m_cnt == 12) found = 1; end
    checks++; if (!found || PWM_PAN !== 1'b1) begin
      failures++; $display("[TB] FAIL rst_mid_pre got=%b found=%0d exp=1", PWM_PAN, found); end
    #2 PRESERN = 1'b0;
    #1;
    checks++; if (PWM_PAN !== 1'b0 || PWM_TILT !== 1'b0) begin
      failures++; $display("[TB] FAIL rst_mid_async got=%b%b exp=00", PWM_PAN, PWM_TILT); end
    @(negedge PCLK); PRESERN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      apb_read(addrs[i], got, exp, err);
      checks++; if (got !== vals[i]) begin
        failures++; $display("[TB] FAIL rst_mid_reg addr=%0h got=%0d exp=%0d", addrs[i], got, vals[i]); end
    end
    apb_write(8'h00, 32'd1, err);
    for (int i = 0; i < 400; i++) begin
      @(negedge PCLK);
      checks++; if (PWM_PAN !== 1'b1 || PWM_TILT !== 1'b1 || PWM_PAN !== m_pan) begin
        failures++; $display("[TB] FAIL rst_mid_run cyc=%0d got=%b%b exp=11", i, PWM_PAN, PWM_TILT); end
    end
    apb_read(8'h14, got, exp, err);
    checks++; if (got !== exp || got < 32'd400) begin
      failures++; $display("[TB] FAIL rst_mid_count got=%0d exp=%0d", got, exp); end
  endtask

  initial begin
    test_reset();
    test_pwm_basic();
    test_double_buffer();
    test_tilt_and_clamp();
    test_errors();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
